// File: rtl/seq_shifter_pkg.sv
// Shared types for the sequential shifter: mode encoding, FSM state
// encoding and a helper that tells whether a mode needs the SHIFT phase.
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN (enables ROL/ROR).
package seq_shifter_pkg;

  typedef enum logic [2:0] {
    MODE_PASS = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_CLR  = 3'b011,
    MODE_SAR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ROR  = 3'b110
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when the mode iterates bit steps; pass, clear and (without the
  // rotate feature) the rotate encodings complete straight from LOAD.
  function automatic logic needs_shift(input logic [2:0] m);
    logic r;
    case (m)
      MODE_SHL: r = 1'b1;
      MODE_SHR: r = 1'b1;
      MODE_SAR: r = 1'b1;
`ifdef SEQ_SHIFTER_ROTATE_EN
      MODE_ROL: r = 1'b1;
      MODE_ROR: r = 1'b1;
`endif
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_shifter_step.sv
// Single-bit step of the shifter datapath (purely combinational).
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN (adds the rotate branches).
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] value,
  input  logic [2:0]   mode,
  output logic [N-1:0] result
);

  // One-bit move of the working value according to the captured mode.
  always_comb begin
    result = value;
    case (mode)
      MODE_SHL: result = {value[N-2:0], 1'b0};
      MODE_SHR: result = {1'b0, value[N-1:1]};
      MODE_SAR: result = {value[N-1], value[N-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
      MODE_ROL: result = {value[N-2:0], value[N-1]};
      MODE_ROR: result = {value[0], value[N-1:1]};
`endif
      default:  result = value;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Sequential shifter: captures an operand, then shifts/rotates it one bit
// per cycle for amt cycles and publishes the result on dout with a
// one-cycle done pulse. Back-to-back starts from DONE skip IDLE.
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN (modes 101/110 rotate;
// without it they behave as pass).
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic signed [N-1:0] din,
  input  logic [SW-1:0]       amt,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] dout
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [2:0]    mode_q;
  logic [SW-1:0] amt_q;
  logic [SW-1:0] count;
  logic [N-1:0]  work;
  logic [N-1:0]  stepped;
  logic          ready;
  logic          load_shift;

  shift_step #(.N(N)) u_step (
    .value  (work),
    .mode   (mode_q),
    .result (stepped)
  );

  // Decode readiness and whether LOAD must hand over to SHIFT.
  always_comb begin
    ready      = (state == S_IDLE) || (state == S_DONE);
    load_shift = needs_shift(mode_q) && (amt_q != {SW{1'b0}});
  end

  // Next-state logic of the control FSM.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
        else       state_nx = S_IDLE;
      end
      S_LOAD: begin
        if (load_shift) state_nx = S_SHIFT;
        else            state_nx = S_DONE;
      end
      S_SHIFT: begin
        if (count == SW'(1)) state_nx = S_DONE;
        else                 state_nx = S_SHIFT;
      end
      S_DONE: begin
        if (start) state_nx = S_LOAD;
        else       state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register plus registered busy/done derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == S_LOAD) || (state_nx == S_SHIFT);
      done  <= (state_nx == S_DONE);
    end
  end

  // Operand capture, iteration counter, working value and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 3'b000;
      amt_q  <= {SW{1'b0}};
      count  <= {SW{1'b0}};
      work   <= {N{1'b0}};
      dout   <= {N{1'b0}};
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (ready && start) begin
            mode_q <= mode;
            amt_q  <= amt;
            work   <= din;
          end
        end
        S_LOAD: begin
          if (load_shift) begin
            count <= amt_q;
          end else if (mode_q == MODE_CLR) begin
            dout <= {N{1'b0}};
          end else begin
            dout <= work;
          end
        end
        S_SHIFT: begin
          work  <= stepped;
          count <= count - SW'(1);
          if (count == SW'(1)) dout <= stepped;
        end
        default: begin
          work <= work;
        end
      endcase
    end
  end

endmodule
